sw_debounce: RTL and testbench

//  Input conditioner for the board slide switches: per-switch 2-flop synchronizer,

---
 rtl/sw_debounce_pkg.sv | 17 +
 rtl/sw_debounce_ch.sv | 92 +++++++++
 rtl/sw_debounce.sv | 35 +++
 tb/tb_sw_debounce.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the slide-switch conditioner: FSM state encoding and
// the default debounce length.
package sw_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } db_st_e;

  localparam int CNT_MAX_DEF = 8;

  // Width of a counter that must hold values 0..m.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchronizer, settle-count filter and registered
// rise/fall pulses that coincide with the debounced level update.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1, s2;
  db_st_e        st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          db_nx, rise_nx, fall_nx;

  // Bring the asynchronous pin into the clock domain; only s2 is used below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Filter state, count, debounced level and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_STABLE;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      db   <= db_nx;
      rise <= rise_nx;
      fall <= fall_nx;
    end
  end

  // Accept a new level only after CNT_MAX consecutive differing samples;
  // any return to the current level drops back to STABLE so a bounce
  // restarts the count from 1 on the next differing sample.
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    db_nx   = db;
    rise_nx = 1'b0;
    fall_nx = 1'b0;
    case (st)
      ST_STABLE: begin
        if (s2 != db) begin
          st_nx  = ST_SETTLE;
          cnt_nx = CNT_ONE;
        end else begin
          cnt_nx = '0;
        end
      end
      ST_SETTLE: begin
        if (s2 == db) begin
          st_nx  = ST_STABLE;
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          db_nx   = s2;
          rise_nx = s2;
          fall_nx = ~s2;
          st_nx   = ST_STABLE;
          cnt_nx  = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        st_nx  = ST_STABLE;
        cnt_nx = '0;
      end
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch input conditioner: N_SW independent debounce channels plus a
// registered "anything changed" flag one cycle behind the pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_SW    = 2,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_changed
);

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(.CNT_MAX(CNT_MAX)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .db   (sw_db[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  // Single flag for any edge on any channel, registered off the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_changed <= 1'b0;
    else        sw_changed <= |(sw_rise | sw_fall);
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (N_SW=2, CNT_MAX=8, 10 ns clock).
module tb_sw_debounce;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_raw;
  logic [1:0] sw_db, sw_rise, sw_fall;
  logic       sw_changed;

  int nchk = 0;
  int nerr = 0;

  // running event counts, sampled 2 ns after each edge
  int rise_tot = 0, fall_tot = 0, rise1_tot = 0, chg_tot = 0;
  int b_rise, b_fall, b_rise1, b_chg;

  sw_debounce #(.N_SW(2), .CNT_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rise_tot  += $countones(sw_rise);
    fall_tot  += $countones(sw_fall);
    rise1_tot += int'(sw_rise[1]);
    chg_tot   += int'(sw_changed);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_rise  = rise_tot;
    b_fall  = fall_tot;
    b_rise1 = rise1_tot;
    b_chg   = chg_tot;
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 2'b00;
    tick(3);
    // 1: reset state and idle hold
    chk("rst_db",  32'(sw_db), 0);
    chk("rst_rise", 32'(sw_rise), 0);
    chk("rst_fall", 32'(sw_fall), 0);
    chk("rst_chg", 32'(sw_changed), 0);
    rst_n = 1'b1;
    snap();
    tick(20);
    chk("idle_db", 32'(sw_db), 0);
    chk("idle_pulses", 32'(rise_tot + fall_tot - b_rise - b_fall), 0);
    chk("idle_chg", 32'(chg_tot - b_chg), 0);

    // 2: 00 -> 01, update lands on the 9th edge after first sample
    sw_raw = 2'b01;
    tick(9);
    chk("t2_db_pre", 32'(sw_db), 32'h0);
    tick(1);
    chk("t2_db", 32'(sw_db), 32'h1);
    chk("t2_rise", 32'(sw_rise), 32'h1);
    chk("t2_fall", 32'(sw_fall), 32'h0);
    chk("t2_chg_early", 32'(sw_changed), 0);
    tick(1);
    chk("t2_rise_off", 32'(sw_rise), 0);
    chk("t2_chg", 32'(sw_changed), 1);
    tick(1);
    chk("t2_chg_off", 32'(sw_changed), 0);

    // 3: bit 1 toggles every 3 cycles, then settles high
    snap();
    for (int k = 0; k < 10; k++) begin
      sw_raw[1] = ~sw_raw[1];
      tick(3);
      chk("t3_db_hold", 32'(sw_db), 32'h1);
    end
    chk("t3_no_rise", 32'(rise1_tot - b_rise1), 0);
    sw_raw[1] = 1'b1;
    tick(9);
    chk("t3_db_pre", 32'(sw_db), 32'h1);
    tick(1);
    chk("t3_db", 32'(sw_db), 32'h3);
    chk("t3_rise", 32'(sw_rise), 32'h2);
    tick(2);
    chk("t3_one_rise", 32'(rise1_tot - b_rise1), 1);

    // 4: 01 -> 10 in one step gives same-cycle rise and fall
    sw_raw = 2'b01;
    tick(12);
    chk("t4_setup", 32'(sw_db), 32'h1);
    snap();
    sw_raw = 2'b10;
    tick(9);
    chk("t4_db_pre", 32'(sw_db), 32'h1);
    tick(1);
    chk("t4_db", 32'(sw_db), 32'h2);
    chk("t4_rise", 32'(sw_rise), 32'h2);
    chk("t4_fall", 32'(sw_fall), 32'h1);
    tick(1);
    chk("t4_chg", 32'(sw_changed), 1);
    tick(1);
    chk("t4_chg_off", 32'(sw_changed), 0);
    tick(1);
    chk("t4_chg_once", 32'(chg_tot - b_chg), 1);

    // 5: reset mid-settle, then switches held high through release
    sw_raw = 2'b11;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_db", 32'(sw_db), 0);
    chk("t5_async_pulse", 32'(sw_rise | sw_fall), 0);
    chk("t5_async_chg", 32'(sw_changed), 0);
    tick(2);
    rst_n = 1'b1;
    snap();
    tick(9);
    chk("t5_db_pre", 32'(sw_db), 32'h0);
    tick(1);
    chk("t5_db", 32'(sw_db), 32'h3);
    chk("t5_rise", 32'(sw_rise), 32'h3);
    tick(1);
    chk("t5_chg", 32'(sw_changed), 1);
    tick(1);
    chk("t5_rise_cnt", 32'(rise_tot - b_rise), 2);
    chk("t5_fall_cnt", 32'(fall_tot - b_fall), 0);

    // 6: sweep 00,01,10,11 with 10-cycle holds
    sw_raw = 2'b00;
    tick(14);
    chk("t6_setup", 32'(sw_db), 0);
    snap();
    for (int v = 0; v < 4; v++) begin
      logic [1:0] prev;
      prev   = sw_db;
      sw_raw = 2'(v);
      tick(9);
      chk("t6_db_pre", 32'(sw_db), 32'(prev));
      tick(1);
      chk("t6_db", 32'(sw_db), 32'(v));
    end
    tick(3);
    chk("t6_pulses", 32'(rise_tot + fall_tot - b_rise - b_fall), 4);
    chk("t6_chg", 32'(chg_tot - b_chg), 3);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
